mxrv_id_stage: RTL and testbench

Registered, parametrised RV32I decode stage that replaces the purely combinational field splitter between fetch and execute. Each instruction accepted from fetch is fully decoded and written into a small in-order output buffer. Decoding covers every base format with sign-extended immediates, register-enable flags and illegal-instruction detection. Valid/ready handshakes on both sides, plus a flush input, let the stage absorb execute back-pressure and branch redirects.

---
 rtl/mxrv_id_stage_if.sv | 49 ++++
 rtl/mxrv_id_stage.sv | 186 ++++++++++++++++++
 tb/tb_mxrv_id_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mxrv_id_stage_if.sv
// mxrv_id_stage_if: fetch-side and execute-side signals of the RV32I decode
// stage, bundled into one interface.
//   slave  - used by mxrv_id_stage (accepts fetch, drives decoded head)
//   master - used by the environment (drives fetch, consumes decoded head)
// Signals: flush, in_valid/in_ready/in_inst/in_pc, out_valid/out_ready,
// out_pc, decoded fields, enables, out_illegal, out_muldiv, out_count.
interface mxrv_id_stage_if #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_we;
  logic            out_rs1_re;
  logic            out_rs2_re;
  logic            out_illegal;
  logic            out_muldiv;
  logic [CW-1:0]   out_count;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_rd_we, out_rs1_re,
           out_rs2_re, out_illegal, out_muldiv, out_count
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_rd_we, out_rs1_re,
           out_rs2_re, out_illegal, out_muldiv, out_count
  );
endinterface

// File: rtl/mxrv_id_stage.sv
// mxrv_id_stage: registered RV32I decode stage. Each accepted instruction is
// decoded combinationally and pushed into a small in-order buffer; execute
// pops the head. flush empties the buffer and blocks same-cycle input.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - synchronous active-high reset
//   bus    - mxrv_id_stage_if.slave (fetch handshake, decoded head, count)
// Optional feature: define MXRV_ID_RVM_EN to accept M-extension OP encodings
// (funct7 0000001) and flag them on out_muldiv.
module mxrv_id_stage #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  mxrv_id_stage_if.slave bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            rs1_re;
    logic            rs2_re;
    logic            illegal;
    logic            muldiv;
  } entry_t;

  entry_t          r_buf [BUF_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;

  logic [31:0]     w_inst;
  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_ill;
  entry_t          w_dec, w_head;
  logic            w_push, w_pop, w_out_valid;

  assign w_inst  = bus.in_inst;
  assign w_op    = w_inst[6:0];
  assign w_f3    = w_inst[14:12];
  assign w_f7    = w_inst[31:25];
  assign w_rd    = w_inst[11:7];
  assign w_rs1   = w_inst[19:15];
  assign w_rs2   = w_inst[24:20];
  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'b0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  always_comb begin
    w_dec        = '0;
    w_ill        = 1'b0;
    w_dec.pc     = bus.in_pc;
    w_dec.opcode = w_op;
    case (w_op)
      7'b0110111, 7'b0010111: begin  // LUI, AUIPC
        w_dec.rd = w_rd; w_dec.imm = XLEN'($signed(w_imm_u)); w_dec.rd_we = |w_rd;
      end
      7'b1101111: begin  // JAL
        w_dec.rd = w_rd; w_dec.imm = XLEN'($signed(w_imm_j)); w_dec.rd_we = |w_rd;
      end
      7'b1100111, 7'b0000011: begin  // JALR, LOAD
        if (w_op == 7'b1100111) w_ill = (w_f3 != 3'b000);
        else                    w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
        w_dec.rd = w_rd; w_dec.rs1 = w_rs1; w_dec.funct3 = w_f3;
        w_dec.imm = XLEN'($signed(w_imm_i)); w_dec.rd_we = |w_rd; w_dec.rs1_re = 1'b1;
      end
      7'b1100011: begin  // BRANCH
        w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
        w_dec.rs1 = w_rs1; w_dec.rs2 = w_rs2; w_dec.funct3 = w_f3;
        w_dec.imm = XLEN'($signed(w_imm_b)); w_dec.rs1_re = 1'b1; w_dec.rs2_re = 1'b1;
      end
      7'b0100011: begin  // STORE
        w_ill = (w_f3[2] || (w_f3 == 3'b011));
        w_dec.rs1 = w_rs1; w_dec.rs2 = w_rs2; w_dec.funct3 = w_f3;
        w_dec.imm = XLEN'($signed(w_imm_s)); w_dec.rs1_re = 1'b1; w_dec.rs2_re = 1'b1;
      end
      7'b0010011: begin  // OP-IMM
        w_dec.rd = w_rd; w_dec.rs1 = w_rs1; w_dec.funct3 = w_f3;
        w_dec.rd_we = |w_rd; w_dec.rs1_re = 1'b1;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // funct7 stays visible on shifts so execute can tell SRLI from SRAI
          w_ill = !((w_f7 == 7'b0000000) || (w_f3 == 3'b101 && w_f7 == 7'b0100000));
          w_dec.funct7 = w_f7;
          w_dec.imm    = XLEN'(w_inst[24:20]);
        end else begin
          w_dec.imm = XLEN'($signed(w_imm_i));
        end
      end
      7'b0110011: begin  // OP
        w_dec.rd = w_rd; w_dec.rs1 = w_rs1; w_dec.rs2 = w_rs2;
        w_dec.funct3 = w_f3; w_dec.funct7 = w_f7;
        w_dec.rd_we = |w_rd; w_dec.rs1_re = 1'b1; w_dec.rs2_re = 1'b1;
        if (w_f7 == 7'b0000000)      w_ill = 1'b0;
        else if (w_f7 == 7'b0100000) w_ill = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
`ifdef MXRV_ID_RVM_EN
        else if (w_f7 == 7'b0000001) w_dec.muldiv = 1'b1;
`endif
        else                         w_ill = 1'b1;
      end
      7'b0001111: begin  // MISC-MEM: fence bits carried in funct3/imm only
        w_dec.funct3 = w_f3; w_dec.imm = XLEN'($signed(w_imm_i));
      end
      7'b1110011: begin  // SYSTEM
        w_dec.funct3 = w_f3;
        if (w_f3 == 3'b000) begin
          w_ill     = (w_inst != 32'h0000_0073) && (w_inst != 32'h0010_0073);
          w_dec.imm = XLEN'($signed(w_imm_i));
        end else if (w_f3 == 3'b100) begin
          w_ill = 1'b1;
        end else begin
          w_dec.rd = w_rd; w_dec.rd_we = |w_rd;
          if (w_f3[2]) begin
            w_dec.imm = XLEN'(w_rs1);  // zimm sits in the rs1 slot
          end else begin
            w_dec.rs1 = w_rs1; w_dec.rs1_re = 1'b1;
            w_dec.imm = XLEN'($signed(w_imm_i));
          end
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (w_inst[1:0] != 2'b11 || w_inst == 32'h0) w_ill = 1'b1;
    if (w_ill) begin
      w_dec         = '0;
      w_dec.pc      = bus.in_pc;
      w_dec.opcode  = w_op;
      w_dec.illegal = 1'b1;
    end
  end

  assign w_out_valid  = (r_count != '0);
  assign bus.in_ready = !bus.flush && (r_count < DEPTH_C);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = w_out_valid && bus.out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_buf[r_wptr] <= w_dec;
  end

  // Empty buffer presents all-zero fields, whatever stale data is stored
  assign w_head = w_out_valid ? r_buf[r_rptr] : '0;

  assign bus.out_valid   = w_out_valid;
  assign bus.out_pc      = w_head.pc;
  assign bus.out_opcode  = w_head.opcode;
  assign bus.out_funct3  = w_head.funct3;
  assign bus.out_funct7  = w_head.funct7;
  assign bus.out_rd      = w_head.rd;
  assign bus.out_rs1     = w_head.rs1;
  assign bus.out_rs2     = w_head.rs2;
  assign bus.out_imm     = w_head.imm;
  assign bus.out_rd_we   = w_head.rd_we;
  assign bus.out_rs1_re  = w_head.rs1_re;
  assign bus.out_rs2_re  = w_head.rs2_re;
  assign bus.out_illegal = w_head.illegal;
  assign bus.out_muldiv  = w_head.muldiv;
  assign bus.out_count   = r_count;
endmodule

// File: tb/tb_mxrv_id_stage.sv
// tb_mxrv_id_stage: directed checks of the RV32I decode stage (BUF_DEPTH 2).
module tb_mxrv_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mxrv_id_stage_if #(.XLEN(32), .PC_W(32), .BUF_DEPTH(2)) bus ();

  mxrv_id_stage #(.XLEN(32), .PC_W(32), .BUF_DEPTH(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_inst = 32'h0; bus.in_pc = 32'h0;
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL rst_valid got=%0h exp=0", bus.out_valid); bad++; end
    total++; if (bus.out_count !== 2'd0) begin $display("FAIL rst_count got=%0h exp=0", bus.out_count); bad++; end
    total++; if (bus.out_imm !== 32'h0) begin $display("FAIL rst_imm got=%0h exp=0", bus.out_imm); bad++; end
    total++; if (bus.out_opcode !== 7'h0 || bus.out_illegal !== 1'b0) begin $display("FAIL rst_fields got=%0h/%0h exp=0/0", bus.out_opcode, bus.out_illegal); bad++; end
    total++; if (bus.in_ready !== 1'b1) begin $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); bad++; end
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    push(32'hFFF10093, 32'h100);
    total++; if (bus.out_valid !== 1'b1) begin $display("FAIL addi_valid got=%0h exp=1", bus.out_valid); bad++; end
    total++; if (bus.out_rd !== 5'd1 || bus.out_rs1 !== 5'd2 || bus.out_rs2 !== 5'd0) begin $display("FAIL addi_regs got=%0d/%0d/%0d exp=1/2/0", bus.out_rd, bus.out_rs1, bus.out_rs2); bad++; end
    total++; if (bus.out_imm !== 32'hFFFFFFFF) begin $display("FAIL addi_imm got=%0h exp=ffffffff", bus.out_imm); bad++; end
    total++; if ({bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re, bus.out_illegal} !== 4'b1100) begin $display("FAIL addi_flags got=%b exp=1100", {bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re, bus.out_illegal}); bad++; end
    total++; if (bus.out_opcode !== 7'b0010011 || bus.out_pc !== 32'h100 || bus.out_count !== 2'd1) begin $display("FAIL addi_op_pc_cnt got=%0h/%0h/%0d exp=13/100/1", bus.out_opcode, bus.out_pc, bus.out_count); bad++; end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_count !== 2'd0) begin $display("FAIL addi_drain got=%0h/%0d exp=0/0", bus.out_valid, bus.out_count); bad++; end
  endtask

  task automatic test_branch();
    push(32'hFE000EE3, 32'h104);
    total++; if (bus.out_imm !== 32'hFFFFFFFC) begin $display("FAIL beq_imm got=%0h exp=fffffffc", bus.out_imm); bad++; end
    total++; if (bus.out_rd !== 5'd0 || bus.out_funct3 !== 3'd0) begin $display("FAIL beq_rd_f3 got=%0d/%0d exp=0/0", bus.out_rd, bus.out_funct3); bad++; end
    total++; if ({bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re, bus.out_illegal} !== 4'b0110) begin $display("FAIL beq_flags got=%b exp=0110", {bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re, bus.out_illegal}); bad++; end
    tick();
  endtask

  task automatic test_formats();
    push(32'h123450B7, 32'h200);  // lui x1,0x12345
    total++; if (bus.out_imm !== 32'h12345000 || bus.out_rd !== 5'd1) begin $display("FAIL lui got=%0h/%0d exp=12345000/1", bus.out_imm, bus.out_rd); bad++; end
    total++; if ({bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re} !== 3'b100) begin $display("FAIL lui_flags got=%b exp=100", {bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re}); bad++; end
    tick();
    push(32'h008000EF, 32'h204);  // jal x1,8
    total++; if (bus.out_imm !== 32'h8 || bus.out_rd !== 5'd1 || bus.out_rd_we !== 1'b1) begin $display("FAIL jal got=%0h/%0d/%0h exp=8/1/1", bus.out_imm, bus.out_rd, bus.out_rd_we); bad++; end
    tick();
    push(32'h00112223, 32'h208);  // sw x1,4(x2)
    total++; if (bus.out_imm !== 32'h4 || bus.out_rs1 !== 5'd2 || bus.out_rs2 !== 5'd1 || bus.out_funct3 !== 3'd2) begin $display("FAIL sw got=%0h/%0d/%0d/%0d exp=4/2/1/2", bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_funct3); bad++; end
    total++; if (bus.out_rd !== 5'd0 || bus.out_rd_we !== 1'b0) begin $display("FAIL sw_rd got=%0d/%0h exp=0/0", bus.out_rd, bus.out_rd_we); bad++; end
    tick();
    push(32'h4030D093, 32'h20C);  // srai x1,x1,3
    total++; if (bus.out_imm !== 32'h3 || bus.out_funct7 !== 7'h20 || bus.out_funct3 !== 3'd5 || bus.out_illegal !== 1'b0) begin $display("FAIL srai got=%0h/%0h/%0d/%0h exp=3/20/5/0", bus.out_imm, bus.out_funct7, bus.out_funct3, bus.out_illegal); bad++; end
    tick();
    push(32'h3003E2F3, 32'h210);  // csrrsi x5,0x300,7
    total++; if (bus.out_imm !== 32'h7 || bus.out_rs1 !== 5'd0 || bus.out_rd !== 5'd5) begin $display("FAIL csri got=%0h/%0d/%0d exp=7/0/5", bus.out_imm, bus.out_rs1, bus.out_rd); bad++; end
    total++; if ({bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re} !== 3'b100) begin $display("FAIL csri_flags got=%b exp=100", {bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re}); bad++; end
    tick();
  endtask

  task automatic test_muldiv();
    push(32'h022081B3, 32'h300);  // mul x3,x1,x2
`ifdef MXRV_ID_RVM_EN
    total++; if (bus.out_muldiv !== 1'b1 || bus.out_illegal !== 1'b0 || bus.out_rd_we !== 1'b1 || bus.out_rd !== 5'd3) begin $display("FAIL mul got=%0h/%0h/%0h/%0d exp=1/0/1/3", bus.out_muldiv, bus.out_illegal, bus.out_rd_we, bus.out_rd); bad++; end
`else
    total++; if (bus.out_muldiv !== 1'b0 || bus.out_illegal !== 1'b1 || bus.out_rd_we !== 1'b0 || bus.out_rd !== 5'd0) begin $display("FAIL mul got=%0h/%0h/%0h/%0d exp=0/1/0/0", bus.out_muldiv, bus.out_illegal, bus.out_rd_we, bus.out_rd); bad++; end
    total++; if (bus.out_opcode !== 7'b0110011 || bus.out_rs1_re !== 1'b0) begin $display("FAIL mul_op got=%0h/%0h exp=33/0", bus.out_opcode, bus.out_rs1_re); bad++; end
`endif
    tick();
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b0;
    push(32'h00000000, 32'h400);
    push(32'h0000007F, 32'h404);
    total++; if (bus.out_count !== 2'd2) begin $display("FAIL ill_count got=%0d exp=2", bus.out_count); bad++; end
    total++; if (bus.out_illegal !== 1'b1 || bus.out_opcode !== 7'h00 || bus.out_imm !== 32'h0) begin $display("FAIL ill0 got=%0h/%0h/%0h exp=1/0/0", bus.out_illegal, bus.out_opcode, bus.out_imm); bad++; end
    total++; if ({bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re, bus.out_muldiv} !== 4'b0000) begin $display("FAIL ill0_en got=%b exp=0000", {bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re, bus.out_muldiv}); bad++; end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_illegal !== 1'b1 || bus.out_opcode !== 7'h7F || bus.out_rd !== 5'd0 || bus.out_pc !== 32'h404) begin $display("FAIL ill7f got=%0h/%0h/%0d/%0h exp=1/7f/0/404", bus.out_illegal, bus.out_opcode, bus.out_rd, bus.out_pc); bad++; end
    total++; if ({bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re} !== 3'b000) begin $display("FAIL ill7f_en got=%b exp=000", {bus.out_rd_we, bus.out_rs1_re, bus.out_rs2_re}); bad++; end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    push(32'h00500093, 32'h500);  // addi x1,x0,5
    total++; if (bus.out_count !== 2'd1 || bus.in_ready !== 1'b1) begin $display("FAIL b2b_one got=%0d/%0h exp=1/1", bus.out_count, bus.in_ready); bad++; end
    push(32'h00A00113, 32'h504);  // addi x2,x0,10
    total++; if (bus.out_count !== 2'd2 || bus.in_ready !== 1'b0) begin $display("FAIL b2b_full got=%0d/%0h exp=2/0", bus.out_count, bus.in_ready); bad++; end
    bus.in_valid = 1'b1; bus.in_inst = 32'h00F00193; bus.in_pc = 32'h508;  // addi x3,x0,15
    tick();
    total++; if (bus.out_count !== 2'd2 || bus.out_imm !== 32'd5 || bus.out_pc !== 32'h500) begin $display("FAIL b2b_hold got=%0d/%0h/%0h exp=2/5/500", bus.out_count, bus.out_imm, bus.out_pc); bad++; end
    bus.out_ready = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b0) begin $display("FAIL b2b_full_pop_ready got=%0h exp=0", bus.in_ready); bad++; end
    tick();
    total++; if (bus.out_count !== 2'd1 || bus.out_imm !== 32'd10 || bus.out_rd !== 5'd2) begin $display("FAIL b2b_second got=%0d/%0h/%0d exp=1/a/2", bus.out_count, bus.out_imm, bus.out_rd); bad++; end
    tick();
    total++; if (bus.out_count !== 2'd1 || bus.out_imm !== 32'd15 || bus.out_rd !== 5'd3) begin $display("FAIL b2b_third got=%0d/%0h/%0d exp=1/f/3", bus.out_count, bus.out_imm, bus.out_rd); bad++; end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.out_count !== 2'd0 || bus.out_valid !== 1'b0) begin $display("FAIL b2b_empty got=%0d/%0h exp=0/0", bus.out_count, bus.out_valid); bad++; end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    push(32'h00500093, 32'h600);
    push(32'h00A00113, 32'h604);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_inst = 32'h06300213; bus.in_pc = 32'h608;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin $display("FAIL flush_ready got=%0h exp=0", bus.in_ready); bad++; end
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; #1;
    total++; if (bus.out_count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0) begin $display("FAIL flush_empty got=%0d/%0h/%0h exp=0/0/0", bus.out_count, bus.out_valid, bus.out_imm); bad++; end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL flush_dropped got=%0h exp=0", bus.out_valid); bad++; end
  endtask

  task automatic test_rst_override();
    bus.out_ready = 1'b0;
    push(32'h00500093, 32'h700);
    push(32'h00A00113, 32'h704);
    rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_inst = 32'h06300213;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0; #1;
    total++; if (bus.out_count !== 2'd0 || bus.out_valid !== 1'b0) begin $display("FAIL rstov_empty got=%0d/%0h exp=0/0", bus.out_count, bus.out_valid); bad++; end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_rd !== 5'd0) begin $display("FAIL rstov_dropped got=%0h/%0d exp=0/0", bus.out_valid, bus.out_rd); bad++; end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_formats();
    test_muldiv();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_rst_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
